gps_capture_ctrl: RTL

GPS_CAPTURE_CTRL -- requirements
Module: gps_capture_ctrl

---
 rtl/gps_capture_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/gps_capture_ctrl.sv
// GPS front-end capture: packs 2-bit samples 16 per word and writes LENGTH words from BASE into sample RAM.
// One-word holding register toward the RAM arbiter; a word completing while the previous one is ungranted is dropped (OVERRUN).
module gps_capture_ctrl #(
    parameter logic [3:0] csr_addr   = 4'h0,
    parameter int         depth_log2 = 11
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [13:0]           csr_a,
    input  logic                  csr_we,
    input  logic [31:0]           csr_di,
    output logic [31:0]           csr_do,
    input  logic                  smp_stb,
    input  logic                  smp_sync,
    input  logic [1:0]            smp_dat,
    output logic                  ram_req,
    input  logic                  ram_gnt,
    output logic [depth_log2-1:0] ram_adr,
    output logic [31:0]           ram_dat,
    output logic                  irq
);

    localparam int LW = depth_log2 + 1;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FLUSH} state_t;
    state_t state, state_nxt;

    logic                  waitsync, done, overrun;
    logic [depth_log2-1:0] base;
    logic [LW-1:0]         length, count, packed_cnt;
    logic [3:0]            pack_idx;
    logic [31:0]           pack_word, word_next, rd_data;

    logic sel, ctrl_wr, start_req, abort_req, busy, start_go, abort_go;
    logic take, word_done, last_word, granted, fsm_done;
    logic unused_bits;

    assign sel       = (csr_a[13:10] == csr_addr);
    assign ctrl_wr   = sel && csr_we && (csr_a[1:0] == 2'd0);
    assign start_req = ctrl_wr && csr_di[0] && !csr_di[1];
    assign abort_req = ctrl_wr && csr_di[1];
    assign busy      = (state != IDLE);
    assign start_go  = start_req && (state == IDLE);
    assign abort_go  = abort_req && busy;
    assign granted   = ram_req && ram_gnt;
    assign take      = smp_stb && (((state == ARMED) && (!waitsync || smp_sync)) || (state == CAPTURE));
    assign word_done = take && (pack_idx == 4'd15);
    assign last_word = word_done && ((packed_cnt + LW'(1)) >= length);
    assign unused_bits = ^{csr_a[9:2], csr_di[31:LW]};

    always_comb begin
        word_next = pack_word;
        word_next[{pack_idx, 1'b0} +: 2] = smp_dat;
    end

    always_comb begin
        rd_data = '0;
        case (csr_a[1:0])
            2'd0: rd_data[3:0] = {waitsync, overrun, done, busy};
            2'd1: rd_data[depth_log2-1:0] = base;
            2'd2: rd_data[LW-1:0] = length;
            default: rd_data[LW-1:0] = count;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fsm_done  = 1'b0;
        case (state)
            IDLE:    if (start_req) state_nxt = ARMED;
            ARMED:   if (take) state_nxt = CAPTURE;
            CAPTURE: if (last_word) state_nxt = FLUSH;
            default: if (!ram_req || ram_gnt) begin
                state_nxt = IDLE;
                fsm_done  = 1'b1;
            end
        endcase
        if (abort_go) begin
            state_nxt = IDLE;
            fsm_done  = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            waitsync   <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
            base       <= '0;
            length     <= LW'(1);
            count      <= '0;
            packed_cnt <= '0;
            pack_idx   <= '0;
            pack_word  <= '0;
            ram_req    <= 1'b0;
            ram_adr    <= '0;
            ram_dat    <= '0;
            irq        <= 1'b0;
            csr_do     <= '0;
        end else begin
            irq    <= 1'b0;
            csr_do <= sel ? rd_data : 32'd0;
            if (ctrl_wr)
                waitsync <= csr_di[2];
            if (sel && csr_we && (csr_a[1:0] == 2'd1))
                base <= csr_di[depth_log2-1:0];
            if (sel && csr_we && (csr_a[1:0] == 2'd2))
                length <= (csr_di[LW-1:0] == '0) ? LW'(1) : csr_di[LW-1:0];

            if (abort_go) begin
                ram_req  <= 1'b0;
                pack_idx <= '0;
            end else begin
                if (start_go) begin
                    done       <= 1'b0;
                    overrun    <= 1'b0;
                    count      <= '0;
                    packed_cnt <= '0;
                    pack_idx   <= '0;
                    ram_adr    <= base;
                end
                if (granted) begin
                    count   <= count + LW'(1);
                    ram_adr <= ram_adr + 1'b1;
                    ram_req <= 1'b0;
                end
                // A grant in this same cycle frees the holding register for the new word.
                if (take) begin
                    pack_word <= word_next;
                    pack_idx  <= pack_idx + 4'd1;
                    if (word_done) begin
                        packed_cnt <= packed_cnt + LW'(1);
                        if (ram_req && !ram_gnt) begin
                            overrun <= 1'b1;
                        end else begin
                            ram_req <= 1'b1;
                            ram_dat <= word_next;
                        end
                    end
                end
                if (fsm_done) begin
                    done <= 1'b1;
                    irq  <= 1'b1;
                end
            end
        end
    end

endmodule
